// File: rtl/call_encoder_if.sv
// ---------------------------------------------------------------------------
// call_encoder_if
// Valid/ready write channel that carries 6-bit call words from call_encoder
// to the call register file.
//   wr_data  [5:0]  call word {called, dir_up, inside, floor[2:0]}
//   wr_valid        wr_data holds a word to transfer
//   wr_ready        downstream accepts; transfer when wr_valid & wr_ready
// Modports: master (encoder side), slave (register file side).
// ---------------------------------------------------------------------------
interface call_encoder_if;
  logic [5:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/call_encoder.sv
// ---------------------------------------------------------------------------
// call_encoder
// Transmit side of the floor-call register write interface. Turns cabin and
// hall button presses plus serve-complete events into 6-bit call words and
// sends them one per valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low
//   btn_inside    cabin floor buttons (level), bit i = floor i
//   btn_up        hall up buttons (level)
//   btn_down      hall down buttons (level)
//   served_valid  one-cycle pulse: car has served served_floor
//   served_floor  floor just served
//   wr            call_encoder_if.master: wr_data / wr_valid / wr_ready
//   err_overflow  sticky: a serve-clear event was dropped, clear FIFO full
//
// Word encoding: inside {1,1,1,f}, up {1,1,0,f}, down {1,0,0,f},
//                serve-clear {0,1,0,f}.
//
// Optional feature: define CALL_ENCODER_DEDUP_EN to keep a per-class "sent"
// mask that suppresses repeat presses of an already-sent call until that
// floor is served.
// ---------------------------------------------------------------------------
module call_encoder #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned CLR_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           btn_inside,
  input  logic [7:0]           btn_up,
  input  logic [7:0]           btn_down,
  input  logic                 served_valid,
  input  logic [2:0]           served_floor,
  call_encoder_if.master       wr,
  output logic                 err_overflow
);

  localparam int unsigned AW = $clog2(CLR_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] FLOOR_MASK = 8'((1 << NUM_FLOORS) - 1);
  // Top floor has no up button, ground floor has no down button.
  localparam logic [7:0] UP_MASK    = FLOOR_MASK & ~(8'd1 << (NUM_FLOORS - 1));
  localparam logic [7:0] DN_MASK    = FLOOR_MASK & 8'hFE;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [5:0]      data_q, data_d;
  logic            err_q, err_d;
  logic [2:0]      rr_q, rr_d;

  logic [7:0]      smp_in_q, smp_in_d, smp_up_q, smp_up_d, smp_dn_q, smp_dn_d;
  logic [7:0]      prv_in_q, prv_in_d, prv_up_q, prv_up_d, prv_dn_q, prv_dn_d;
  logic [7:0]      pend_in_q, pend_in_d, pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;

  logic [2:0]      mem_q [CLR_DEPTH];
  logic [2:0]      mem_d [CLR_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

`ifdef CALL_ENCODER_DEDUP_EN
  logic [7:0]      sent_in_q, sent_in_d, sent_up_q, sent_up_d, sent_dn_q, sent_dn_d;
`endif

  // Combinational working signals
  logic [7:0]      srv_mask;
  logic [7:0]      edge_in, edge_up, edge_dn;
  logic [7:0]      xfer_mask, xfer_in, xfer_up, xfer_dn;
  logic [7:0]      avail_in, avail_up, avail_dn;
  logic            xfer, xfer_call, pop, push, full;
  logic [CW-1:0]   cnt_eff;
  logic [2:0]      head_eff;
  logic [3:0]      pick_in, pick_up, pick_dn;
  logic            any;
  logic [5:0]      sel_word;

  // Lowest set bit of m at or above start, wrapping to floor 0.
  // Returns {found, floor}.
  function automatic logic [3:0] pick(input logic [7:0] m, input logic [2:0] start);
    logic [3:0]  r;
    int unsigned s;
    logic [2:0]  idx;
    r = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      s = {29'd0, start} + i;
      if (s >= NUM_FLOORS) s = s - NUM_FLOORS;
      idx = s[2:0];
      if (!r[3] && m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    // Defaults: hold state
    state_d   = state_q;
    data_d    = data_q;
    err_d     = err_q;
    rr_d      = rr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;

    smp_in_d  = btn_inside & FLOOR_MASK;
    smp_up_d  = btn_up     & UP_MASK;
    smp_dn_d  = btn_down   & DN_MASK;
    prv_in_d  = smp_in_q;
    prv_up_d  = smp_up_q;
    prv_dn_d  = smp_dn_q;

    srv_mask  = served_valid ? ((8'd1 << served_floor) & FLOOR_MASK) : '0;

    edge_in   = smp_in_q & ~prv_in_q;
    edge_up   = smp_up_q & ~prv_up_q;
    edge_dn   = smp_dn_q & ~prv_dn_q;
`ifdef CALL_ENCODER_DEDUP_EN
    // A serve in the same cycle re-arms the floor before the edge is judged.
    edge_in   = edge_in & ~(sent_in_q & ~srv_mask);
    edge_up   = edge_up & ~(sent_up_q & ~srv_mask);
    edge_dn   = edge_dn & ~(sent_dn_q & ~srv_mask);
`endif

    xfer      = (state_q == SEND) && wr.wr_ready;
    xfer_call = xfer &&  data_q[5];
    pop       = xfer && !data_q[5];
    xfer_mask = 8'd1 << data_q[2:0];
    xfer_in   = (xfer_call &&  data_q[3])               ? xfer_mask : '0;
    xfer_up   = (xfer_call &&  data_q[4] && !data_q[3]) ? xfer_mask : '0;
    xfer_dn   = (xfer_call && !data_q[4] && !data_q[3]) ? xfer_mask : '0;

    // Work still eligible for selection after this cycle's transfer and serve.
    avail_in  = pend_in_q & ~xfer_in & ~srv_mask;
    avail_up  = pend_up_q & ~xfer_up & ~srv_mask;
    avail_dn  = pend_dn_q & ~xfer_dn & ~srv_mask;

    // Press edge is OR'ed in last so it wins over a same-cycle serve.
    pend_in_d = avail_in | edge_in;
    pend_up_d = avail_up | edge_up;
    pend_dn_d = avail_dn | edge_dn;

`ifdef CALL_ENCODER_DEDUP_EN
    sent_in_d = (sent_in_q & ~srv_mask) | xfer_in;
    sent_up_d = (sent_up_q & ~srv_mask) | xfer_up;
    sent_dn_d = (sent_dn_q & ~srv_mask) | xfer_dn;
`endif

    if (xfer_call)
      rr_d = (data_q[2:0] == 3'(NUM_FLOORS - 1)) ? 3'd0 : data_q[2:0] + 3'd1;

    // Serve-clear FIFO; a pop frees a slot for a same-cycle push when full.
    full = (cnt_q == CW'(CLR_DEPTH));
    push = served_valid && (!full || pop);
    if (served_valid && full && !pop) err_d = 1'b1;
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push) begin
      mem_d[wptr_q] = served_floor;
      wptr_d        = wptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // View of the FIFO head once the word now on the bus has been popped,
    // so the same-cycle reload never resends it.
    cnt_eff  = pop ? cnt_q - CW'(1) : cnt_q;
    head_eff = pop ? mem_q[rptr_q + AW'(1)] : mem_q[rptr_q];

    pick_in  = pick(avail_in, rr_d);
    pick_up  = pick(avail_up, rr_d);
    pick_dn  = pick(avail_dn, rr_d);

    any      = 1'b1;
    if (cnt_eff != '0)   sel_word = {3'b010, head_eff};
    else if (pick_in[3]) sel_word = {3'b111, pick_in[2:0]};
    else if (pick_up[3]) sel_word = {3'b110, pick_up[2:0]};
    else if (pick_dn[3]) sel_word = {3'b100, pick_dn[2:0]};
    else begin
      sel_word = '0;
      any      = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (any) begin
          data_d  = sel_word;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (any) data_d  = sel_word;
          else     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      err_q     <= 1'b0;
      rr_q      <= '0;
      smp_in_q  <= '0;
      smp_up_q  <= '0;
      smp_dn_q  <= '0;
      prv_in_q  <= '0;
      prv_up_q  <= '0;
      prv_dn_q  <= '0;
      pend_in_q <= '0;
      pend_up_q <= '0;
      pend_dn_q <= '0;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
`ifdef CALL_ENCODER_DEDUP_EN
      sent_in_q <= '0;
      sent_up_q <= '0;
      sent_dn_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      err_q     <= err_d;
      rr_q      <= rr_d;
      smp_in_q  <= smp_in_d;
      smp_up_q  <= smp_up_d;
      smp_dn_q  <= smp_dn_d;
      prv_in_q  <= prv_in_d;
      prv_up_q  <= prv_up_d;
      prv_dn_q  <= prv_dn_d;
      pend_in_q <= pend_in_d;
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
`ifdef CALL_ENCODER_DEDUP_EN
      sent_in_q <= sent_in_d;
      sent_up_q <= sent_up_d;
      sent_dn_q <= sent_dn_d;
`endif
    end
  end

  assign wr.wr_data    = data_q;
  assign wr.wr_valid   = (state_q == SEND);
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_call_encoder.sv
// ---------------------------------------------------------------------------
// tb_call_encoder
// Scoreboard bench for call_encoder: stimulus pushes the hand-computed call
// words it expects; an independent monitor pops and compares on every
// handshake. Direct checks cover reset values, latency, hold stability and
// the overflow flag.
// ---------------------------------------------------------------------------
module tb_call_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bi, bu, bd;
  logic       sv;
  logic [2:0] sf;
  logic       err_ov;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  call_encoder_if wr_if();

  call_encoder #(.NUM_FLOORS(8), .CLR_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_inside   (bi),
    .btn_up       (bu),
    .btn_down     (bd),
    .served_valid (sv),
    .served_floor (sf),
    .wr           (wr_if),
    .err_overflow (err_ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %b expected none", wr_if.wr_data);
      end else begin
        check("word", {26'd0, wr_if.wr_data}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    bi = '1; bu = '1; bd = '1;
    sv = 1'b0; sf = '0;
    wr_if.wr_ready = 1'b0;

    // 1. Reset with buttons active
    #12;
    @(negedge clk);
    check("rst_valid", {31'd0, wr_if.wr_valid}, 32'd0);
    check("rst_data",  {26'd0, wr_if.wr_data},  32'd0);
    check("rst_err",   {31'd0, err_ov},         32'd0);
    bi = '0; bu = '0; bd = '0;
    cyc(2);
    wr_if.wr_ready = 1'b1;
    reset = 1'b1;
    cyc(8);

    // 2. Single inside press, latency 3 cycles
    exp_q.push_back(6'b111_101);
    bi[5] = 1'b1;
    @(negedge clk);
    check("lat_n0", {31'd0, wr_if.wr_valid}, 32'd0);
    @(posedge clk); #1;
    bi = '0;
    @(negedge clk);
    check("lat_n1", {31'd0, wr_if.wr_valid}, 32'd0);
    @(negedge clk);
    check("lat_n2", {31'd0, wr_if.wr_valid}, 32'd0);
    @(negedge clk);
    check("lat_n3_valid", {31'd0, wr_if.wr_valid}, 32'd1);
    check("lat_n3_data",  {26'd0, wr_if.wr_data},  {26'd0, 6'b111_101});
    cyc(6);

    // 3. Three classes same cycle: priority inside > up > down
    exp_q.push_back(6'b111_001);
    exp_q.push_back(6'b110_010);
    exp_q.push_back(6'b100_110);
    bi[1] = 1'b1; bu[2] = 1'b1; bd[6] = 1'b1;
    cyc(1);
    bi = '0; bu = '0; bd = '0;
    cyc(8);

    // Ignored buttons: up on top floor, down on ground floor
    bu[7] = 1'b1; bd[0] = 1'b1;
    cyc(1);
    bu = '0; bd = '0;
    cyc(8);

    // 4. Held word stable under backpressure; served meanwhile does not retract it
    wr_if.wr_ready = 1'b0;
    exp_q.push_back(6'b111_111);
    exp_q.push_back(6'b010_111);
    bi[7] = 1'b1;
    cyc(1);
    bi = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wr_if.wr_valid !== 1'b1 && n < 20);
    check("hold_valid_seen", {31'd0, wr_if.wr_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, wr_if.wr_valid}, 32'd1);
      check("hold_data",  {26'd0, wr_if.wr_data},  {26'd0, 6'b111_111});
      @(posedge clk); #1;
      sv = (k == 1);
      sf = 3'd7;
    end
    sv = 1'b0;
    wr_if.wr_ready = 1'b1;
    cyc(8);

    // 5. Clear FIFO overflow
    check("ovf_before", {31'd0, err_ov}, 32'd0);
    wr_if.wr_ready = 1'b0;
    exp_q.push_back(6'b010_000);
    exp_q.push_back(6'b010_001);
    sv = 1'b1; sf = 3'd0;
    cyc(1);
    sf = 3'd1;
    cyc(1);
    sf = 3'd2;
    cyc(1);
    sv = 1'b0;
    cyc(1);
    @(negedge clk);
    check("ovf_set", {31'd0, err_ov}, 32'd1);
    @(posedge clk); #1;
    wr_if.wr_ready = 1'b1;
    cyc(8);
    @(negedge clk);
    check("ovf_sticky", {31'd0, err_ov}, 32'd1);

    // Press edge and serve on the same floor/class in the same cycle: press wins
    @(posedge clk); #1;
    exp_q.push_back(6'b010_100);
    exp_q.push_back(6'b100_100);
    bd[4] = 1'b1;
    cyc(1);
    bd = '0;
    sv = 1'b1; sf = 3'd4;
    cyc(1);
    sv = 1'b0;
    cyc(8);

    // 6. Repeat press without serve
    exp_q.push_back(6'b110_011);
`ifndef CALL_ENCODER_DEDUP_EN
    exp_q.push_back(6'b110_011);
`endif
    bu[3] = 1'b1;
    cyc(1);
    bu = '0;
    cyc(6);
    bu[3] = 1'b1;
    cyc(1);
    bu = '0;
    cyc(8);

    // Drain scoreboard, bounded
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc(1);
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);

    // Reset asserted mid-transfer: output drops at once, work discarded
    wr_if.wr_ready = 1'b0;
    bi[2] = 1'b1;
    cyc(1);
    bi = '0;
    cyc(4);
    @(negedge clk);
    check("mid_valid_before", {31'd0, wr_if.wr_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid_drop", {31'd0, wr_if.wr_valid}, 32'd0);
    check("mid_data_clr",   {26'd0, wr_if.wr_data},  32'd0);
    check("mid_err_clr",    {31'd0, err_ov},         32'd0);
    cyc(2);
    reset = 1'b1;
    wr_if.wr_ready = 1'b1;
    cyc(10);
    check("final_left", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
